// File: rtl/dmux.sv
// dmux: routes 134-bit packet words from the OS packet input to one of three
// consumers (PGM, LCM, SSM). The head word's select fields choose the
// destination. The whole packet and its valid flag follow the head to that
// consumer, with one clock of latency.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   pktin_data / _wr                 input word and its strobe
//   pktin_data_valid / _valid_wr     packet keep/discard flag and its strobe
//   dmux2{pgm,lcm,ssm}_data / _wr    registered word and strobe per consumer
//   dmux2{pgm,lcm,ssm}_data_valid / _valid_wr
//                                    registered valid flag and strobe per consumer
module dmux #(
    parameter int unsigned DW = 134
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pktin_data,
    input  logic          pktin_data_wr,
    input  logic          pktin_data_valid,
    input  logic          pktin_data_valid_wr,
    output logic [DW-1:0] dmux2pgm_data,
    output logic          dmux2pgm_data_wr,
    output logic          dmux2pgm_data_valid,
    output logic          dmux2pgm_data_valid_wr,
    output logic [DW-1:0] dmux2lcm_data,
    output logic          dmux2lcm_data_wr,
    output logic          dmux2lcm_data_valid,
    output logic          dmux2lcm_data_valid_wr,
    output logic [DW-1:0] dmux2ssm_data,
    output logic          dmux2ssm_data_wr,
    output logic          dmux2ssm_data_valid,
    output logic          dmux2ssm_data_valid_wr
);

    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b10;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PGM  = 2'd1;
    localparam logic [1:0] LCM  = 2'd2;
    localparam logic [1:0] SSM  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [1:0]    head_dst;
    logic [1:0]    word_dst;
    logic [1:0]    word_type;
    logic [7:0]    sel_a;
    logic [2:0]    sel_b;
    logic          is_head;
    logic          is_tail;

    logic [DW-1:0] pgm_data_nxt, lcm_data_nxt, ssm_data_nxt;
    logic          pgm_wr_nxt, lcm_wr_nxt, ssm_wr_nxt;
    logic          pgm_v_nxt, lcm_v_nxt, ssm_v_nxt;
    logic          pgm_vwr_nxt, lcm_vwr_nxt, ssm_vwr_nxt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Decode, next state and next output values
    always_comb begin
        state_nxt    = state;
        pgm_data_nxt = '0;
        lcm_data_nxt = '0;
        ssm_data_nxt = '0;
        pgm_wr_nxt   = 1'b0;
        lcm_wr_nxt   = 1'b0;
        ssm_wr_nxt   = 1'b0;
        pgm_v_nxt    = 1'b0;
        lcm_v_nxt    = 1'b0;
        ssm_v_nxt    = 1'b0;
        pgm_vwr_nxt  = 1'b0;
        lcm_vwr_nxt  = 1'b0;
        ssm_vwr_nxt  = 1'b0;

        word_type = pktin_data[DW-1:DW-2];
        sel_a     = pktin_data[DW-7:DW-14];
        sel_b     = pktin_data[DW-23:DW-25];
        is_head   = pktin_data_wr && (word_type == TYPE_HEAD);
        is_tail   = pktin_data_wr && (word_type == TYPE_TAIL);

        // SSM wins over the LCM code.
        if (sel_a != 8'h00) begin
            head_dst = SSM;
        end else if (sel_b == 3'b111) begin
            head_dst = LCM;
        end else begin
            head_dst = PGM;
        end

        // A head always routes by its own decode, even when a packet is still open.
        word_dst = is_head ? head_dst : state;

        if (is_head) begin
            state_nxt = head_dst;
        end else if (is_tail) begin
            state_nxt = IDLE;
        end

        if (pktin_data_wr) begin
            case (word_dst)
                PGM: begin pgm_wr_nxt = 1'b1; pgm_data_nxt = pktin_data; end
                LCM: begin lcm_wr_nxt = 1'b1; lcm_data_nxt = pktin_data; end
                SSM: begin ssm_wr_nxt = 1'b1; ssm_data_nxt = pktin_data; end
                default: ;
            endcase
        end

        if (pktin_data_valid_wr) begin
            case (word_dst)
                PGM: begin pgm_vwr_nxt = 1'b1; pgm_v_nxt = pktin_data_valid; end
                LCM: begin lcm_vwr_nxt = 1'b1; lcm_v_nxt = pktin_data_valid; end
                SSM: begin ssm_vwr_nxt = 1'b1; ssm_v_nxt = pktin_data_valid; end
                default: ;
            endcase
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmux2pgm_data          <= '0;
            dmux2pgm_data_wr       <= 1'b0;
            dmux2pgm_data_valid    <= 1'b0;
            dmux2pgm_data_valid_wr <= 1'b0;
            dmux2lcm_data          <= '0;
            dmux2lcm_data_wr       <= 1'b0;
            dmux2lcm_data_valid    <= 1'b0;
            dmux2lcm_data_valid_wr <= 1'b0;
            dmux2ssm_data          <= '0;
            dmux2ssm_data_wr       <= 1'b0;
            dmux2ssm_data_valid    <= 1'b0;
            dmux2ssm_data_valid_wr <= 1'b0;
        end else begin
            dmux2pgm_data          <= pgm_data_nxt;
            dmux2pgm_data_wr       <= pgm_wr_nxt;
            dmux2pgm_data_valid    <= pgm_v_nxt;
            dmux2pgm_data_valid_wr <= pgm_vwr_nxt;
            dmux2lcm_data          <= lcm_data_nxt;
            dmux2lcm_data_wr       <= lcm_wr_nxt;
            dmux2lcm_data_valid    <= lcm_v_nxt;
            dmux2lcm_data_valid_wr <= lcm_vwr_nxt;
            dmux2ssm_data          <= ssm_data_nxt;
            dmux2ssm_data_wr       <= ssm_wr_nxt;
            dmux2ssm_data_valid    <= ssm_v_nxt;
            dmux2ssm_data_valid_wr <= ssm_vwr_nxt;
        end
    end

endmodule

// File: tb/tb_dmux.sv
// tb_dmux: directed vector table plus randomized traffic checked against a
// packet-level reference model of the demultiplexer.
module tb_dmux;

    localparam int unsigned DW = 134;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pktin_data;
    logic          pktin_data_wr;
    logic          pktin_data_valid;
    logic          pktin_data_valid_wr;
    logic [DW-1:0] pgm_d, lcm_d, ssm_d;
    logic          pgm_wr, lcm_wr, ssm_wr;
    logic          pgm_v, lcm_v, ssm_v;
    logic          pgm_vwr, lcm_vwr, ssm_vwr;

    dmux #(.DW(DW)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .pktin_data             (pktin_data),
        .pktin_data_wr          (pktin_data_wr),
        .pktin_data_valid       (pktin_data_valid),
        .pktin_data_valid_wr    (pktin_data_valid_wr),
        .dmux2pgm_data          (pgm_d),
        .dmux2pgm_data_wr       (pgm_wr),
        .dmux2pgm_data_valid    (pgm_v),
        .dmux2pgm_data_valid_wr (pgm_vwr),
        .dmux2lcm_data          (lcm_d),
        .dmux2lcm_data_wr       (lcm_wr),
        .dmux2lcm_data_valid    (lcm_v),
        .dmux2lcm_data_valid_wr (lcm_vwr),
        .dmux2ssm_data          (ssm_d),
        .dmux2ssm_data_wr       (ssm_wr),
        .dmux2ssm_data_valid    (ssm_v),
        .dmux2ssm_data_valid_wr (ssm_vwr)
    );

    always #5 clk = ~clk;

    // Destination codes used by the bench: 0 none, 1 PGM, 2 LCM, 3 SSM
    typedef struct {
        logic [DW-1:0] d;
        logic          wr;
        logic          v;
        logic          vwr;
        int            dst;
        int            vdst;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cur_pkt = 0;   // model: destination of the open packet, 0 if none

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [7:0] sa,
                                         input logic [2:0] sb);
        logic [31:0] p;
        p  = $urandom;
        mk = {t, 4'hf, sa, 8'h00, sb, 77'd0, p};
    endfunction

    function automatic int route(input logic [DW-1:0] d);
        if (d[127:120] != 8'h00) return 3;
        if (d[111:109] == 3'b111) return 2;
        return 1;
    endfunction

    task automatic add(input logic [DW-1:0] d, input logic wr, input logic v,
                       input logic vwr, input int dst, input int vdst);
        vec_t e;
        e.d = d; e.wr = wr; e.v = v; e.vwr = vwr; e.dst = dst; e.vdst = vdst;
        tbl.push_back(e);
    endtask

    // Packet-level model: which consumer a word / valid flag belongs to
    task automatic model(input vec_t e, output int dst, output int vdst);
        int owner;
        logic head;
        head  = e.wr && (e.d[133:132] == 2'b01);
        owner = head ? route(e.d) : cur_pkt;
        dst   = e.wr  ? owner : 0;
        vdst  = e.vwr ? owner : 0;
        if (head) cur_pkt = owner;
        else if (e.wr && e.d[133:132] == 2'b10) cur_pkt = 0;
    endtask

    task automatic check(input string name, input vec_t e);
        logic [2:0] ewr, evwr, ev, gwr, gvwr, gv;
        logic [DW-1:0] ed [3];
        logic dok;
        for (int k = 0; k < 3; k++) begin
            ewr[k]  = (e.dst == k + 1);
            evwr[k] = (e.vdst == k + 1);
            ev[k]   = evwr[k] ? e.v : 1'b0;
            ed[k]   = ewr[k] ? e.d : '0;
        end
        gwr  = {ssm_wr, lcm_wr, pgm_wr};
        gvwr = {ssm_vwr, lcm_vwr, pgm_vwr};
        gv   = {ssm_v, lcm_v, pgm_v};
        dok  = (pgm_d === ed[0]) && (lcm_d === ed[1]) && (ssm_d === ed[2]);
        n_vec++;
        if (gwr !== ewr || gvwr !== evwr || gv !== ev || !dok) begin
            n_err++;
            $display("FAIL %s vec%0d: got wr=%b vwr=%b v=%b data_ok=%b, need wr=%b vwr=%b v=%b",
                     name, n_vec, gwr, gvwr, gv, dok, ewr, evwr, ev);
        end
    endtask

    // Drive one cycle, then compare the registered result after the edge
    task automatic apply(input string name, input vec_t e);
        pktin_data          = e.d;
        pktin_data_wr       = e.wr;
        pktin_data_valid    = e.v;
        pktin_data_valid_wr = e.vwr;
        @(posedge clk);
        #1;
        check(name, e);
    endtask

    initial begin
        vec_t e;
        int md, mv;
        rst = 1'b1;
        pktin_data = '0; pktin_data_wr = 1'b0;
        pktin_data_valid = 1'b0; pktin_data_valid_wr = 1'b0;

        // Directed table with hand-derived expectations
        add(mk(2'b01, 8'h00, 3'b001), 1, 0, 0, 1, 0);                  // PGM packet
        for (int i = 0; i < 4; i++) add(mk(2'b11, 8'h00, 3'b000), 1, 0, 0, 1, 0);
        add(mk(2'b10, 8'h00, 3'b000), 1, 1, 1, 1, 1);
        add(mk(2'b01, 8'h00, 3'b001), 0, 0, 0, 0, 0);                  // wr=0 ignored
        add(mk(2'b01, 8'h00, 3'b111), 1, 0, 0, 2, 0);                  // LCM packet
        for (int i = 0; i < 5; i++) add(mk(2'b11, 8'h00, 3'b000), 1, 0, 0, 2, 0);
        add(mk(2'b10, 8'h00, 3'b000), 1, 0, 1, 2, 2);
        add(mk(2'b01, 8'h01, 3'b111), 1, 0, 0, 3, 0);                  // SSM back-to-back
        for (int i = 0; i < 6; i++) add(mk(2'b11, 8'h00, 3'b111), 1, 0, 0, 3, 0);
        add(mk(2'b10, 8'h00, 3'b000), 1, 1, 1, 3, 3);
        add(mk(2'b11, 8'h00, 3'b000), 1, 0, 0, 0, 0);                  // orphans in IDLE
        add(mk(2'b10, 8'h00, 3'b000), 1, 1, 1, 0, 0);
        add(mk(2'b00, 8'h00, 3'b111), 1, 0, 0, 0, 0);
        add('0, 0, 1, 1, 0, 0);
        add(mk(2'b01, 8'h00, 3'b010), 1, 0, 0, 1, 0);                  // head without tail
        add(mk(2'b11, 8'h00, 3'b000), 1, 0, 0, 1, 0);
        add(mk(2'b11, 8'h00, 3'b000), 1, 0, 0, 1, 0);
        add(mk(2'b01, 8'h80, 3'b000), 1, 0, 0, 3, 0);
        add(mk(2'b11, 8'h00, 3'b000), 1, 0, 0, 3, 0);
        add('0, 0, 0, 1, 0, 3);                                         // valid mid-packet
        add(mk(2'b10, 8'h00, 3'b000), 1, 0, 0, 3, 0);
        add(mk(2'b01, 8'h00, 3'b111), 1, 1, 1, 2, 2);                  // valid with head
        add(mk(2'b10, 8'h00, 3'b000), 1, 0, 0, 2, 0);

        repeat (2) @(posedge clk);
        #1;
        e.d = '0; e.wr = 0; e.v = 0; e.vwr = 0; e.dst = 0; e.vdst = 0;
        check("reset", e);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            model(tbl[i], md, mv);
            apply("table", tbl[i]);
        end

        // Reset in the middle of an LCM packet
        e.v = 0; e.vwr = 0;
        for (int i = 0; i < 3; i++) begin
            e.d = mk(i == 0 ? 2'b01 : 2'b11, 8'h00, 3'b111); e.wr = 1;
            e.dst = 2; e.vdst = 0;
            model(e, md, mv);
            apply("rst_pre", e);
        end
        pktin_data_wr = 1'b0;
        rst = 1'b1;
        cur_pkt = 0;
        #1;
        e.wr = 0; e.dst = 0;
        check("rst_async", e);
        @(negedge clk);
        rst = 1'b0;
        e.d = mk(2'b11, 8'h00, 3'b111); e.wr = 1; e.dst = 0;
        apply("rst_drop_mid", e);
        e.d = mk(2'b10, 8'h00, 3'b111); e.vwr = 1; e.v = 1; e.dst = 0; e.vdst = 0;
        apply("rst_drop_tail", e);
        e.d = mk(2'b01, 8'h00, 3'b000); e.vwr = 0; e.v = 0; e.dst = 1;
        model(e, md, mv);
        apply("rst_next_head", e);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] t;
            logic [7:0] sa;
            t  = 2'($urandom_range(0, 3));
            sa = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            e.d   = mk(t, sa, 3'($urandom_range(0, 7)));
            e.wr  = ($urandom_range(0, 3) != 0);
            e.v   = 1'($urandom);
            e.vwr = ($urandom_range(0, 3) == 0);
            model(e, md, mv);
            e.dst = md; e.vdst = mv;
            apply("random", e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmux.md
Name: dmux

Overview:
- Packet demultiplexer between the FPGA OS packet input and three consumers: PGM (packet generator), LCM (local control), and SSM (status/statistics).
- Each packet arrives as a stream of 134-bit words. The head word selects one destination.
- The whole packet, plus its end-of-packet valid flag, is forwarded unmodified to that destination only, with one clock of latency.

Parameters:
- DW, 134, data word width (fixed format; the decode field positions below assume 134).

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  asynchronous, active-high reset
- pktin_data  in  134  input packet word
- pktin_data_wr  in  1  word strobe; pktin_data is sampled when high
- pktin_data_valid  in  1  packet-valid flag; 1 = keep packet, 0 = discard
- pktin_data_valid_wr  in  1  strobe for pktin_data_valid; asserted on the tail-word cycle
- dmux2pgm_data  out  134  word to PGM
- dmux2pgm_data_wr  out  1  word strobe to PGM
- dmux2pgm_data_valid  out  1  valid flag to PGM
- dmux2pgm_data_valid_wr  out  1  valid-flag strobe to PGM
- dmux2lcm_data / _wr / _valid / _valid_wr  out  134/1/1/1  same set of signals, to LCM
- dmux2ssm_data / _wr / _valid / _valid_wr  out  134/1/1/1  same set of signals, to SSM

Behaviour:
- Word format, bits [133:132] = word type:
  - 2'b01 head
  - 2'b11 middle
  - 2'b10 tail
  - 2'b00 invalid
- Word format, other fields:
  - [131:128] byte-valid count, passed through untouched
  - [127:120] = sel_a
  - [119:112] reserved
  - [111:109] = sel_b
  - [108:0] payload
- Route decode, evaluated only on a head word (pktin_data_wr=1, type 01):
  - sel_a != 8'h00 → SSM
  - else sel_b == 3'b111 → LCM
  - else → PGM
- FSM states: IDLE, PGM, LCM, SSM. Reset state is IDLE.
  - IDLE + head word → state of the decoded destination.
  - Any routed state + tail word (wr=1, type 10) → IDLE.
  - Any state + head word → re-decode and enter the new state. This handles a missing tail; the new packet's head is forwarded to the new destination.
  - IDLE + middle, tail or type-00 word → word dropped, no output strobe.
  - Words with pktin_data_wr=0 are ignored; the state holds.
- Datapath: every output is registered, with exactly one cycle of latency.
  - A word accepted at edge N appears on the selected dmux2X_data, with dmux2X_data_wr=1, after edge N.
  - The head word is routed by its own decode, not the previous state.
  - Non-selected destinations in that cycle: _wr=0, _data=0.
  - When no word is accepted, all _wr=0 and all _data=0.
- Valid path: when pktin_data_valid_wr=1, drive the registered copy with one cycle of latency:
  - dmux2X_data_valid_wr=1 and dmux2X_data_valid=pktin_data_valid.
  - X is the destination of the packet currently routed; when valid_wr coincides with the tail, this is the tail's destination.
  - In IDLE with no same-cycle head, valid_wr is dropped.
  - All other _valid and _valid_wr outputs are 0.
- Back-to-back packets with no idle cycle between the tail and the next head are supported.
- Reset value of all outputs is 0, and the state is IDLE.
- Reset asserted mid-packet: outputs clear immediately and the state returns to IDLE. Remaining words of that packet are dropped until the next head word.
- No backpressure: the block accepts one word per clock unconditionally.

Test Plan:
- Packet to PGM:
  - Stimulus: head {01,0000,00,00,001,0} then middles 1..4 and tail 5, tail with valid=1 and valid_wr=1.
  - Response: 6 words on dmux2pgm_data, each delayed one cycle; dmux2pgm_data_valid_wr=1 and _valid=1 on the tail output cycle; LCM and SSM strobes stay 0.
- Packet to LCM:
  - Stimulus: sel_a=0, sel_b=111, 7 words.
  - Response: all 7 words appear only on LCM, one cycle late; valid strobe to LCM only.
- Packet to SSM:
  - Stimulus: sel_a=8'h01, sel_b=111, 8 words.
  - Response: all 8 words appear only on SSM; SSM takes priority over the LCM code.
- Orphan words:
  - Stimulus: middle/tail words with wr=1 while in IDLE.
  - Response: no strobe on any output.
- Head without tail:
  - Stimulus: PGM head, 2 middles, then an SSM head without a tail in between.
  - Response: the new head and its following words go to SSM, and PGM stops.
- Reset mid-packet:
  - Stimulus: assert rst after the 3rd word of an LCM packet, then release.
  - Response: outputs become 0 at once; the packet's remaining words are dropped until the next head.
